// File: rtl/prach_pkg.sv
// rtl/prach_pkg.sv - shared constants, coefficients and output rounding for the PRACH half-band interpolator
package prach_pkg;

    localparam int DATA_W     = 16;
    localparam int COEF_W     = 18;
    localparam int ACC_W      = 38;
    localparam int NTAP_UNIQ  = 6;
    localparam int NTAP_PHASE = 2 * NTAP_UNIQ;
    localparam int CTR_TAP    = 5;
    localparam int LAT        = 5;

    // Q1.17 taps h[0],h[2],...,h[10] of the gain-2 filter; mirrored for h[12..22], sum 65536.
    localparam logic signed [COEF_W-1:0] COEF [NTAP_UNIQ] = '{
        18'sd132, -18'sd516, 18'sd1408, -18'sd3200, 18'sd6784, 18'sd60928
    };

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(65536);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -ACC_W'(32768);

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] v;
        v = (acc + RND_HALF) >>> (COEF_W - 1);
        if (v > SAT_MAX)
            return 16'sh7FFF;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/prach_hb2_interp_ch.sv
// rtl/prach_hb2_interp_ch.sv - one I or Q lane: per-channel history, symmetric pre-add, MAC, round/saturate
module prach_hb2_interp_ch
    import prach_pkg::*;
#(
    parameter int NUM_CHN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout_dp1,
    output logic signed [DATA_W-1:0] dout_dp2
);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;

    logic signed [DATA_W-1:0] r_hist [NTAP_PHASE][NUM_CHN];
    logic signed [DATA_W-1:0] w_x    [NTAP_PHASE];
    logic signed [PRE_W-1:0]  r_pre  [NTAP_UNIQ];
    logic signed [PROD_W-1:0] r_prod [NTAP_UNIQ];
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_ctr  [3];

    // Head of each stage holds the same channel's sample k frames back.
    always_comb begin
        for (int k = 0; k < NTAP_PHASE; k++)
            w_x[k] = r_hist[k][0];
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAP_UNIQ; k++)
            w_sum = w_sum + ACC_W'(r_prod[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NTAP_PHASE; s++)
                for (int j = 0; j < NUM_CHN; j++)
                    r_hist[s][j] <= '0;
        end else begin
            r_hist[0][0] <= din;
            for (int s = 1; s < NTAP_PHASE; s++)
                r_hist[s][0] <= r_hist[s-1][NUM_CHN-1];
            for (int s = 0; s < NTAP_PHASE; s++)
                for (int j = 1; j < NUM_CHN; j++)
                    r_hist[s][j] <= r_hist[s][j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAP_UNIQ; k++) begin
                r_pre[k]  <= '0;
                r_prod[k] <= '0;
            end
            for (int i = 0; i < 3; i++)
                r_ctr[i] <= '0;
            r_acc    <= '0;
            dout_dp1 <= '0;
            dout_dp2 <= '0;
        end else begin
            for (int k = 0; k < NTAP_UNIQ; k++) begin
                r_pre[k]  <= PRE_W'(w_x[k]) + PRE_W'(w_x[NTAP_PHASE-1-k]);
                r_prod[k] <= PROD_W'(r_pre[k]) * PROD_W'(COEF[k]);
            end
            r_acc    <= w_sum;
            r_ctr[0] <= w_x[CTR_TAP];
            r_ctr[1] <= r_ctr[0];
            r_ctr[2] <= r_ctr[1];
            dout_dp1 <= round_sat(r_acc);
            dout_dp2 <= r_ctr[2];
        end
    end

endmodule

// File: rtl/prach_hb2_interp.sv
// rtl/prach_hb2_interp.sv - TDM half-band x2 interpolator top; sequence checker built with PRACH_HB2_INTERP_CHK_EN
module prach_hb2_interp
    import prach_pkg::*;
#(
    parameter int NUM_CHN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0][DATA_W-1:0] din_dq,
    input  logic [7:0]             din_chn,
    input  logic                   sync_in,
    output logic [1:0][DATA_W-1:0] dout_dp1,
    output logic [1:0][DATA_W-1:0] dout_dp2,
    output logic [7:0]             dout_chn,
    output logic                   sync_out,
    output logic                   err_seq
);
    logic signed [DATA_W-1:0] w_dp1_i, w_dp1_q, w_dp2_i, w_dp2_q;
    logic [7:0]               r_chn_d [LAT];
    logic [LAT-1:0]           r_sync_d;

    prach_hb2_interp_ch #(.NUM_CHN(NUM_CHN)) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .din      (din_dq[0]),
        .dout_dp1 (w_dp1_i),
        .dout_dp2 (w_dp2_i)
    );

    prach_hb2_interp_ch #(.NUM_CHN(NUM_CHN)) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .din      (din_dq[1]),
        .dout_dp1 (w_dp1_q),
        .dout_dp2 (w_dp2_q)
    );

    assign dout_dp1 = {w_dp1_q, w_dp1_i};
    assign dout_dp2 = {w_dp2_q, w_dp2_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                r_chn_d[i] <= '0;
            r_sync_d <= '0;
        end else begin
            r_chn_d[0] <= din_chn;
            for (int i = 1; i < LAT; i++)
                r_chn_d[i] <= r_chn_d[i-1];
            r_sync_d <= {r_sync_d[LAT-2:0], sync_in};
        end
    end

    assign dout_chn = r_chn_d[LAT-1];
    assign sync_out = r_sync_d[LAT-1];

`ifdef PRACH_HB2_INTERP_CHK_EN
    localparam logic [7:0] LAST_CHN = 8'(NUM_CHN - 1);

    logic       r_armed;
    logic       r_err;
    logic [7:0] r_prev_chn;
    logic [7:0] w_exp_chn;
    logic       w_bad;

    // Order is only enforced once the first frame boundary has been seen.
    always_comb begin
        w_exp_chn = (r_prev_chn == LAST_CHN) ? 8'd0 : r_prev_chn + 8'd1;
        w_bad     = (sync_in && din_chn != 8'd0) || (r_armed && din_chn != w_exp_chn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_err      <= 1'b0;
            r_prev_chn <= '0;
        end else begin
            r_armed    <= r_armed | sync_in;
            r_err      <= r_err | w_bad;
            r_prev_chn <= din_chn;
        end
    end

    assign err_seq = r_err;
`else
    assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb2_interp.sv
// tb/tb_prach_hb2_interp.sv - directed self-checking bench for prach_hb2_interp
module tb_prach_hb2_interp;

    localparam int NREC = 512;

`ifdef PRACH_HB2_INTERP_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0][15:0]  din_dq = '0;
    logic [7:0]        din_chn = '0;
    logic              sync_in = 1'b0;
    logic [1:0][15:0]  dout_dp1, dout_dp2;
    logic [7:0]        dout_chn;
    logic              sync_out, err_seq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [15:0] rec_i1 [NREC];
    logic signed [15:0] rec_q1 [NREC];
    logic signed [15:0] rec_i2 [NREC];
    logic signed [15:0] rec_q2 [NREC];
    logic [7:0]         rec_chn [NREC];
    logic               rec_sync [NREC];
    logic               rec_err [NREC];

    prach_hb2_interp #(.NUM_CHN(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din_dq   (din_dq),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err_seq  (err_seq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Record index k holds the outputs produced by the input driven at index k-5.
    task automatic tick(input logic [15:0] vi, input logic [15:0] vq, input logic [7:0] ch, input logic sy);
        @(negedge clk);
        if (cyc < NREC) begin
            rec_i1[cyc]   = dout_dp1[0];
            rec_q1[cyc]   = dout_dp1[1];
            rec_i2[cyc]   = dout_dp2[0];
            rec_q2[cyc]   = dout_dp2[1];
            rec_chn[cyc]  = dout_chn;
            rec_sync[cyc] = sync_out;
            rec_err[cyc]  = err_seq;
        end
        din_dq[0] = vi;
        din_dq[1] = vq;
        din_chn   = ch;
        sync_in   = sy;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_dq = '0;
        din_chn = '0;
        sync_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic pos_sign(input int f);
        int k;
        k = (f < 6) ? f : 11 - f;
        return !(k == 1 || k == 3);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (dout_dp1 !== 32'h0) begin errors++; $display("FAIL reset_dp1: got %h expected 0", dout_dp1); end
        checks++; if (dout_dp2 !== 32'h0) begin errors++; $display("FAIL reset_dp2: got %h expected 0", dout_dp2); end
        checks++; if (dout_chn !== 8'h0) begin errors++; $display("FAIL reset_chn: got %h expected 0", dout_chn); end
        checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", sync_out); end
        checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_seq); end
    endtask

    task automatic test_impulse();
        int exp_i [12] = '{17, -64, 176, -400, 848, 7616, 7616, 848, -400, 176, -64, 17};
        int exp_q [12] = '{-16, 65, -176, 400, -848, -7616, -7616, -848, 400, -176, 65, -16};
        logic [15:0] vi, vq;
        logic signed [15:0] e2i, e2q;
        logic nz;
        int idx;
        do_reset();
        for (int f = 0; f < 14; f++)
            for (int c = 0; c < 8; c++) begin
                vi = (f == 0 && c == 3) ? 16'h4000 : 16'h0000;
                vq = (f == 0 && c == 3) ? 16'hC000 : 16'h0000;
                tick(vi, vq, 8'(c), c == 0);
            end
        for (int j = 0; j < 12; j++) begin
            idx = j * 8 + 3 + 5;
            e2i = (j == 5) ? 16'sh4000 : 16'sh0000;
            e2q = (j == 5) ? 16'shC000 : 16'sh0000;
            checks++; if (rec_i1[idx] !== 16'(exp_i[j])) begin errors++; $display("FAIL impulse_dp1_i frame %0d: got %0d expected %0d", j, rec_i1[idx], exp_i[j]); end
            checks++; if (rec_q1[idx] !== 16'(exp_q[j])) begin errors++; $display("FAIL impulse_dp1_q frame %0d: got %0d expected %0d", j, rec_q1[idx], exp_q[j]); end
            checks++; if (rec_i2[idx] !== e2i) begin errors++; $display("FAIL impulse_dp2_i frame %0d: got %0d expected %0d", j, rec_i2[idx], e2i); end
            checks++; if (rec_q2[idx] !== e2q) begin errors++; $display("FAIL impulse_dp2_q frame %0d: got %0d expected %0d", j, rec_q2[idx], e2q); end
            checks++; if (rec_chn[idx] !== 8'd3) begin errors++; $display("FAIL impulse_chn frame %0d: got %0d expected 3", j, rec_chn[idx]); end
            nz = 1'b0;
            for (int c = 0; c < 8; c++)
                if (c != 3)
                    nz = nz | (rec_i1[j*8+c+5] != 0) | (rec_q1[j*8+c+5] != 0) | (rec_i2[j*8+c+5] != 0) | (rec_q2[j*8+c+5] != 0);
            checks++; if (nz !== 1'b0) begin errors++; $display("FAIL impulse_other_chn frame %0d: got nonzero %b expected 0", j, nz); end
        end
    endtask

    task automatic test_dc();
        int idx;
        do_reset();
        for (int f = 0; f < 14; f++)
            for (int c = 0; c < 8; c++)
                tick(16'h7FFF, 16'h8000, 8'(c), c == 0);
        for (int c = 0; c < 8; c++) begin
            idx = 12 * 8 + c + 5;
            checks++; if (rec_i1[idx] !== 16'sh7FFF) begin errors++; $display("FAIL dc_dp1_i chn %0d: got %0d expected 32767", c, rec_i1[idx]); end
            checks++; if (rec_q1[idx] !== 16'sh8000) begin errors++; $display("FAIL dc_dp1_q chn %0d: got %0d expected -32768", c, rec_q1[idx]); end
            checks++; if (rec_i2[idx] !== 16'sh7FFF) begin errors++; $display("FAIL dc_dp2_i chn %0d: got %0d expected 32767", c, rec_i2[idx]); end
            checks++; if (rec_q2[idx] !== 16'sh8000) begin errors++; $display("FAIL dc_dp2_q chn %0d: got %0d expected -32768", c, rec_q2[idx]); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] vi, vq;
        int idx;
        do_reset();
        for (int f = 0; f < 14; f++)
            for (int c = 0; c < 8; c++) begin
                vi = 16'h0000;
                vq = 16'h0000;
                if (c == 0) begin
                    vi = (f % 2 == 0) ? 16'h7FFF : 16'h8000;
                    if (f < 12) vq = pos_sign(f) ? 16'h7FFF : 16'h8000;
                end
                if (c == 1 && f < 12) vq = pos_sign(f) ? 16'h8000 : 16'h7FFF;
                tick(vi, vq, 8'(c), c == 0);
            end
        // Alternating full-scale cancels pairwise to -1, giving exactly -0.5 which rounds up to 0.
        for (int f = 11; f < 14; f++) begin
            idx = f * 8 + 5;
            checks++; if (rec_i1[idx] !== 16'sh0000) begin errors++; $display("FAIL sat_alt_dp1 frame %0d: got %0d expected 0", f, rec_i1[idx]); end
        end
        checks++; if (rec_q1[11*8+0+5] !== 16'sh7FFF) begin errors++; $display("FAIL sat_pos_dp1: got %0d expected 32767", rec_q1[11*8+5]); end
        checks++; if (rec_q1[11*8+1+5] !== 16'sh8000) begin errors++; $display("FAIL sat_neg_dp1: got %0d expected -32768", rec_q1[11*8+6]); end
    endtask

    task automatic test_latency();
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 8; c++)
                tick(16'h0000, 16'h0000, 8'(c), c == 0);
        checks++; if (rec_sync[4] !== 1'b0) begin errors++; $display("FAIL lat_sync_t4: got %b expected 0", rec_sync[4]); end
        checks++; if (rec_sync[5] !== 1'b1) begin errors++; $display("FAIL lat_sync_t5: got %b expected 1", rec_sync[5]); end
        checks++; if (rec_chn[5] !== 8'd0) begin errors++; $display("FAIL lat_chn_t5: got %0d expected 0", rec_chn[5]); end
        checks++; if (rec_sync[6] !== 1'b0) begin errors++; $display("FAIL lat_sync_t6: got %b expected 0", rec_sync[6]); end
        checks++; if (rec_chn[9] !== 8'd4) begin errors++; $display("FAIL lat_chn_t9: got %0d expected 4", rec_chn[9]); end
        checks++; if (rec_sync[13] !== 1'b1) begin errors++; $display("FAIL lat_sync_t13: got %b expected 1", rec_sync[13]); end
    endtask

    task automatic test_checker();
        do_reset();
        tick(16'h0000, 16'h0000, 8'd5, 1'b0);
        tick(16'h0000, 16'h0000, 8'd2, 1'b0);
        tick(16'h0000, 16'h0000, 8'd7, 1'b0);
        for (int c = 0; c < 8; c++)
            tick(16'h0000, 16'h0000, 8'(c), c == 0);
        for (int c = 0; c < 8; c++)
            if (c != 4) tick(16'h0000, 16'h0000, 8'(c), c == 0);
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 8; c++)
                tick(16'h0000, 16'h0000, 8'(c), c == 0);
        checks++; if (rec_err[3] !== 1'b0) begin errors++; $display("FAIL chk_pre_sync: got %b expected 0", rec_err[3]); end
        checks++; if (rec_err[15] !== 1'b0) begin errors++; $display("FAIL chk_before_skip: got %b expected 0", rec_err[15]); end
        checks++; if (rec_err[16] !== CHK_EN) begin errors++; $display("FAIL chk_after_skip: got %b expected %b", rec_err[16], CHK_EN); end
        checks++; if (rec_err[33] !== CHK_EN) begin errors++; $display("FAIL chk_sticky: got %b expected %b", rec_err[33], CHK_EN); end
    endtask

    task automatic test_reset_midstream();
        logic nz;
        logic bad_sync;
        do_reset();
        for (int t = 0; t < 12; t++)
            tick(16'h1234, 16'h4321, 8'(t % 8), (t % 8) == 0);
        checks++; if (rec_i1[11] !== 16'sd5) begin errors++; $display("FAIL mid_pre_i: got %0d expected 5", rec_i1[11]); end
        checks++; if (rec_q1[11] !== 16'sd17) begin errors++; $display("FAIL mid_pre_q: got %0d expected 17", rec_q1[11]); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (dout_dp1 !== 32'h0) begin errors++; $display("FAIL mid_rst_dp1: got %h expected 0", dout_dp1); end
        checks++; if (dout_dp2 !== 32'h0) begin errors++; $display("FAIL mid_rst_dp2: got %h expected 0", dout_dp2); end
        checks++; if (dout_chn !== 8'h0) begin errors++; $display("FAIL mid_rst_chn: got %h expected 0", dout_chn); end
        checks++; if (sync_out !== 1'b0) begin errors++; $display("FAIL mid_rst_sync: got %b expected 0", sync_out); end
        @(negedge clk);
        rst = 1'b0;
        din_dq = '0;
        din_chn = '0;
        sync_in = 1'b0;
        cyc = 0;
        for (int t = 0; t < 16; t++)
            tick(16'h0000, 16'h0000, 8'(t % 8), (t % 8) == 0);
        nz = 1'b0;
        bad_sync = 1'b0;
        for (int k = 0; k < 16; k++) begin
            nz = nz | (rec_i1[k] != 0) | (rec_q1[k] != 0) | (rec_i2[k] != 0) | (rec_q2[k] != 0);
            if (k < 5) bad_sync = bad_sync | rec_sync[k];
        end
        checks++; if (nz !== 1'b0) begin errors++; $display("FAIL mid_zero_out: got nonzero %b expected 0", nz); end
        checks++; if (bad_sync !== 1'b0) begin errors++; $display("FAIL mid_first_lat_sync: got %b expected 0", bad_sync); end
        checks++; if (rec_sync[5] !== 1'b1) begin errors++; $display("FAIL mid_sync_t5: got %b expected 1", rec_sync[5]); end
    endtask

    initial begin
        #1;
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_latency();
        test_checker();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prach_hb2_interp.md
PRACH_HB2_INTERP -- requirements
Module: prach_hb2_interp

Interface
REQ-001 SHALL have parameter NUM_CHN, default 8, meaning TDM channel count (2..256).
REQ-002 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have din_dq  input  16 x2  I/Q sample, signed Q1.15, one per cycle.
REQ-005 SHALL have din_chn  input  8  channel index of din_dq.
REQ-006 SHALL have sync_in  input  1  high with channel 0 of each TDM frame.
REQ-007 SHALL have dout_dp1  output  16 x2  first interpolated phase per channel, signed Q1.15.
REQ-008 SHALL have dout_dp2  output  16 x2  second interpolated phase per channel, signed Q1.15.
REQ-009 SHALL have dout_chn  output  8  din_chn delayed by the pipeline latency.
REQ-010 SHALL have sync_out  output  1  sync_in delayed by the pipeline latency.
REQ-011 SHALL have err_seq  output  1  sticky channel-sequence error flag.

Function
REQ-012 SHALL implement a 23-tap half-band interpolator by 2, gain 2, independently per I/Q lane and per channel.
REQ-013 SHALL hold per-channel history x[n..n-11] as 12 shift stages of depth NUM_CHN each, advanced every cycle; channels arrive strictly 0..NUM_CHN-1 repeating.
REQ-014 SHALL compute dout_dp1 = sum k=0..11 of h[2k]*x[n-k], symmetric pairs pre-added (17 bit) before multiply.
REQ-015 SHALL compute dout_dp2 = x[n-5] of the same channel (center tap 0.5 times gain 2), delay-matched to dout_dp1.
REQ-016 SHALL use 6 unique signed 18-bit Q1.17 coefficients summing to 65536 (DC gain 1.0 per phase).
REQ-017 SHALL accumulate at 38 bits, round half-up at bit 17, saturate to [-32768, 32767].
REQ-018 SHALL have fixed latency LAT = 5 cycles from din_dq/din_chn/sync_in to dout_dp1/dout_dp2/dout_chn/sync_out; no stalls, no back-pressure.
REQ-019 SHALL set err_seq when sync_in=1 with din_chn!=0, or din_chn != (previous din_chn+1) mod NUM_CHN after the first sync_in since reset.
REQ-020 SHALL keep err_seq set until rst; a sequence error SHALL NOT alter filter data path.
REQ-021 SHALL ignore sequence checking before the first sync_in after reset.

Reset
REQ-022 SHALL clear on rst all history stages, pipeline registers, dout_dp1, dout_dp2, dout_chn, sync_out and err_seq to 0.
REQ-023 SHALL, on rst mid-stream, restart from zero history; first LAT outputs after release are 0 with sync_out=0.

Configuration
REQ-024 SHALL compile the sequence checker only when macro PRACH_HB2_INTERP_CHK_EN is defined.
REQ-025 SHALL, without PRACH_HB2_INTERP_CHK_EN, drive err_seq constant 0 and synthesize no checker logic; data path identical.

Structure
REQ-026 SHALL place coefficient array, NTAP_UNIQ=6, COEF_W=18, ACC_W=38 and LAT=5 in shared package prach_pkg.
REQ-027 SHALL implement one lane in sub-module prach_hb2_interp_ch, instantiated twice (I, Q); top derives dout_chn/sync_out/err_seq once.

Verification
REQ-028 SHALL verify impulse: din_dq=0x4000 on chn 3 once, else 0 -> chn 3 dout_dp1 over next 12 frames equals h[2k]/8 rounded, dout_dp2 = 0x4000 in frame 5 only, other channels 0.
REQ-029 SHALL verify DC: constant 0x7FFF all channels -> after 12 frames dout_dp1=dout_dp2=0x7FFF, no wrap.
REQ-030 SHALL verify saturation: alternating +/-32768 per frame on chn 0 -> dout_dp1 clipped within [-32768, 32767], never wraps.
REQ-031 SHALL verify latency: sync_in at cycle t -> sync_out at t+5, dout_chn=0 same cycle.
REQ-032 SHALL verify checker: skip chn 4 in one frame -> err_seq=1 and stays 1; undefined macro -> err_seq=0.
REQ-033 SHALL verify reset: assert rst mid-frame with nonzero history -> all outputs 0 immediately; zero input afterwards yields all-zero output.
